seg7_scan_driver: RTL

- Downstream consumer of the binary-to-decimal converter: takes its five BCD digits (dig_i[4:0], 8 bits each) and its sign code (8'hD = minus, 8'h00 = positive).
- Time-multiplexes them onto a 6-position common-anode 7-segment display.
- One-deep pending buffer with valid/ready handshake; new values take effect only at a frame boundary, so a scan frame never shows a mix of old and new digits.
- Leading-zero blanking and undefined-digit ('E') indication are applied at decode time.

---
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Six-position common-anode 7-segment scan driver with frame-aligned valid/ready update.
// Optional anode-switch guard blanking is enabled by defining SEG7_GHOST_BLANK_EN.
module seg7_scan_driver #(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0][7:0] dig_i,
    input  logic [7:0]      sign_i,
    output logic [5:0]      an_o,
    output logic [6:0]      seg_o
);

    localparam int         CW         = $clog2(CLK_DIV);
    localparam logic [7:0] SIGN_MINUS = 8'h0D;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_MINUS  = 7'h3F;
    localparam logic [6:0] SEG_ERR    = 7'h06;

    if (CLK_DIV < 8 || CLK_DIV > (1 << 20) || GUARD >= CLK_DIV) begin : g_bad_params
        $error("seg7_scan_driver: illegal CLK_DIV/GUARD combination");
    end

    function automatic logic [6:0] f_decode(input logic [7:0] d);
        logic [6:0] s;
        case (d)
            8'd0:    s = 7'h40;
            8'd1:    s = 7'h79;
            8'd2:    s = 7'h24;
            8'd3:    s = 7'h30;
            8'd4:    s = 7'h19;
            8'd5:    s = 7'h12;
            8'd6:    s = 7'h02;
            8'd7:    s = 7'h78;
            8'd8:    s = 7'h00;
            8'd9:    s = 7'h10;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic            r_pend_full;
    logic [4:0][7:0] r_pend_dig;
    logic [7:0]      r_pend_sign;
    logic [4:0][7:0] r_disp_dig;
    logic [7:0]      r_disp_sign;
    logic [5:0]      r_an;
    logic [6:0]      r_seg;

    logic            w_tick;
    logic            w_frame_end;
    logic            w_accept;
    logic [4:1]      w_nz;
    logic [5:0]      w_an_next;
    logic [6:0]      w_seg_next;

    assign w_tick      = (r_cnt == CW'(CLK_DIV - 1));
    assign w_frame_end = w_tick && (r_idx == 3'd5);
    assign w_accept    = valid_i && !r_pend_full;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // NOTE: the display register is reset too, since reset must show a defined 0 rather than stale digits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend_full <= 1'b0;
            r_pend_dig  <= '0;
            r_pend_sign <= '0;
            r_disp_dig  <= '0;
            r_disp_sign <= '0;
        end else if (w_accept) begin
            // Acceptance needs an empty buffer, so it can never coincide with a transfer to display.
            r_pend_dig  <= dig_i;
            r_pend_sign <= sign_i;
            r_pend_full <= 1'b1;
        end else if (w_frame_end && r_pend_full) begin
            r_disp_dig  <= r_pend_dig;
            r_disp_sign <= r_pend_sign;
            r_pend_full <= 1'b0;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_nz[4]    = |r_disp_dig[4];
        w_nz[3]    = |r_disp_dig[3] | w_nz[4];
        w_nz[2]    = |r_disp_dig[2] | w_nz[3];
        w_nz[1]    = |r_disp_dig[1] | w_nz[2];
        w_an_next  = ~(6'b000001 << r_idx);
        w_seg_next = SEG_BLANK;
        case (r_idx)
            3'd0:    w_seg_next = f_decode(r_disp_dig[0]);
            3'd1:    w_seg_next = w_nz[1] ? f_decode(r_disp_dig[1]) : SEG_BLANK;
            3'd2:    w_seg_next = w_nz[2] ? f_decode(r_disp_dig[2]) : SEG_BLANK;
            3'd3:    w_seg_next = w_nz[3] ? f_decode(r_disp_dig[3]) : SEG_BLANK;
            3'd4:    w_seg_next = w_nz[4] ? f_decode(r_disp_dig[4]) : SEG_BLANK;
            3'd5:    w_seg_next = (r_disp_sign == SIGN_MINUS) ? SEG_MINUS : SEG_BLANK;
            default: w_seg_next = SEG_BLANK;
        endcase
`ifdef SEG7_GHOST_BLANK_EN
        if (r_cnt < CW'(GUARD)) begin
            w_an_next  = 6'h3F;
            w_seg_next = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_an  <= 6'h3F;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign ready_o = !r_pend_full;

endmodule
